// File: rtl/param_call_stack_if.sv
// Bus bundle for param_call_stack: operation controls in, top-of-stack and status out.
// WIDTH/DEPTH must match the parameters of the attached param_call_stack.
interface param_call_stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             en;
   logic             push;
   logic             pop;
   logic             flush;
   logic             err_clr;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output en, push, pop, flush, err_clr, data_in,
      input  data_out, count, empty, full, overflow, underflow
   );

   modport slave (
      input  en, push, pop, flush, err_clr, data_in,
      output data_out, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/param_call_stack.sv
// Parametrised return-address stack with registered top-of-stack and sticky error flags.
// Define PARAM_CALL_STACK_WRAP_EN for circular mode (push while full overwrites oldest).
module param_call_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input logic               clk,
   input logic               rst_n,
   param_call_stack_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_TWO  = AW'(2);
   localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    sp_r;
   logic [AW-1:0]    sp_s;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_s;
   logic [WIDTH-1:0] top_r;
   logic [WIDTH-1:0] top_s;
   logic [WIDTH-1:0] below_s;
   logic             ovf_r;
   logic             udf_r;
   logic             ovf_set_s;
   logic             udf_set_s;
   logic             wr_en_s;
   logic [AW-1:0]    wr_addr_s;
   logic             is_empty_s;
   logic             is_full_s;

   // sp_r is the next free slot, so the entry beneath the top sits two below it
   assign is_empty_s = (count_r == CNT_ZERO);
   assign is_full_s  = (count_r == CNT_MAX);
   assign below_s    = mem_r[sp_r - PTR_TWO];

   // Next-state decode in priority order flush > push&pop > push > pop
   always_comb begin
      sp_s      = sp_r;
      count_s   = count_r;
      top_s     = top_r;
      wr_en_s   = 1'b0;
      wr_addr_s = sp_r;
      ovf_set_s = 1'b0;
      udf_set_s = 1'b0;
      if (!bus.en) begin
         sp_s = sp_r;
      end else if (bus.flush) begin
         sp_s    = PTR_ZERO;
         count_s = CNT_ZERO;
         top_s   = {WIDTH{1'b0}};
      end else if (bus.push && bus.pop) begin
         top_s   = bus.data_in;
         wr_en_s = 1'b1;
         if (is_empty_s) begin
            udf_set_s = 1'b1;
            sp_s      = sp_r + PTR_ONE;
            count_s   = CNT_ONE;
         end else begin
            wr_addr_s = sp_r - PTR_ONE;
         end
      end else if (bus.push) begin
         if (is_full_s) begin
            ovf_set_s = 1'b1;
`ifdef PARAM_CALL_STACK_WRAP_EN
            // With count at DEPTH, sp_r points at the oldest entry
            wr_en_s   = 1'b1;
            sp_s      = sp_r + PTR_ONE;
            top_s     = bus.data_in;
`else
            wr_en_s   = 1'b0;
`endif
         end else begin
            wr_en_s = 1'b1;
            sp_s    = sp_r + PTR_ONE;
            count_s = count_r + CNT_ONE;
            top_s   = bus.data_in;
         end
      end else if (bus.pop) begin
         if (is_empty_s) begin
            udf_set_s = 1'b1;
         end else begin
            sp_s    = sp_r - PTR_ONE;
            count_s = count_r - CNT_ONE;
            top_s   = (count_r == CNT_ONE) ? {WIDTH{1'b0}} : below_s;
         end
      end else begin
         sp_s = sp_r;
      end
   end

   // Pointer, count, top-of-stack and sticky flag registers; frozen while en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_r    <= PTR_ZERO;
         count_r <= CNT_ZERO;
         top_r   <= {WIDTH{1'b0}};
         ovf_r   <= 1'b0;
         udf_r   <= 1'b0;
      end else if (bus.en) begin
         sp_r    <= sp_s;
         count_r <= count_s;
         top_r   <= top_s;
         ovf_r   <= ovf_set_s | (ovf_r & ~bus.err_clr);
         udf_r   <= udf_set_s | (udf_r & ~bus.err_clr);
      end else begin
         sp_r    <= sp_r;
         count_r <= count_r;
         top_r   <= top_r;
         ovf_r   <= ovf_r;
         udf_r   <= udf_r;
      end
   end

   // Entry storage, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_addr_s] <= bus.data_in;
      end
   end

   assign bus.data_out  = top_r;
   assign bus.count     = count_r;
   assign bus.empty     = is_empty_s;
   assign bus.full      = is_full_s;
   assign bus.overflow  = ovf_r;
   assign bus.underflow = udf_r;
endmodule

// File: tb/tb_param_call_stack.sv
// Directed table-driven bench for param_call_stack (WIDTH=32, DEPTH=4), either overflow mode.
module tb_param_call_stack;
   localparam int W = 32;
   localparam int D = 4;

   typedef struct {
      logic        en, push, pop, flush, clr;
      logic [31:0] din;
      logic [31:0] dout;
      logic [2:0]  cnt;
      logic        ovf, udf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;
   vec_t vecs[$];

   param_call_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

   param_call_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void v(input logic en, input logic push, input logic pop,
                             input logic flush, input logic clr, input logic [31:0] din,
                             input logic [31:0] dout, input logic [2:0] cnt,
                             input logic ovf, input logic udf);
      vec_t t;
      t.en = en; t.push = push; t.pop = pop; t.flush = flush; t.clr = clr;
      t.din = din; t.dout = dout; t.cnt = cnt; t.ovf = ovf; t.udf = udf;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [31:0] dout, input logic [2:0] cnt,
                            input logic ovf, input logic udf);
      n_vec++;
      chk("data_out",  idx, bus.data_out, dout);
      chk("count",     idx, 32'(bus.count), 32'(cnt));
      chk("empty",     idx, 32'(bus.empty), 32'(cnt == 3'd0));
      chk("full",      idx, 32'(bus.full), 32'(cnt == 3'd4));
      chk("overflow",  idx, 32'(bus.overflow), 32'(ovf));
      chk("underflow", idx, 32'(bus.underflow), 32'(udf));
   endtask

   task automatic idle();
      bus.en = 1'b1; bus.push = 1'b0; bus.pop = 1'b0;
      bus.flush = 1'b0; bus.err_clr = 1'b0; bus.data_in = 32'h0;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      // en push pop flush clr din | dout cnt ovf udf
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h100, 32'h100,3'd1,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h200, 32'h200,3'd2,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h300, 32'h300,3'd3,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h200,3'd2,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h100,3'd1,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'hA,   32'hA,  3'd1,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'hB,   32'hB,  3'd2,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'hC,   32'hC,  3'd3,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'hD,   32'hD,  3'd4,1'b0,1'b0);
`ifdef PARAM_CALL_STACK_WRAP_EN
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'hE,   32'hE,  3'd4,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'hD,  3'd3,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'hC,  3'd2,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'hB,  3'd1,1'b1,1'b0);
`else
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'hE,   32'hD,  3'd4,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'hC,  3'd3,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'hB,  3'd2,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'hA,  3'd1,1'b1,1'b0);
`endif
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b1,1'b1);
      v(1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,   32'h0,  3'd0,1'b0,1'b0);
      // replace-top and underflow
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h10,  32'h10, 3'd1,1'b0,1'b0);
      v(1'b1,1'b1,1'b1,1'b0,1'b0,32'h20,  32'h20, 3'd1,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b0,1'b1);
      v(1'b1,1'b1,1'b1,1'b0,1'b0,32'h30,  32'h30, 3'd1,1'b0,1'b1);
      v(1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,   32'h30, 3'd1,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b1,32'h0,   32'h0,  3'd0,1'b0,1'b1);
      v(1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,   32'h0,  3'd0,1'b0,1'b0);
      // stall and flush
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h40,  32'h40, 3'd1,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h50,  32'h50, 3'd2,1'b0,1'b0);
      v(1'b0,1'b1,1'b1,1'b1,1'b1,32'h99,  32'h50, 3'd2,1'b0,1'b0);
      v(1'b0,1'b1,1'b0,1'b0,1'b0,32'h98,  32'h50, 3'd2,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b1,1'b0,32'h55,  32'h0,  3'd0,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h0,  3'd0,1'b0,1'b1);
      v(1'b0,1'b0,1'b1,1'b0,1'b1,32'h0,   32'h0,  3'd0,1'b0,1'b1);
      v(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,   32'h0,  3'd0,1'b0,1'b1);
      v(1'b1,1'b0,1'b0,1'b1,1'b1,32'h0,   32'h0,  3'd0,1'b0,1'b0);
      // push&pop while full is not an overflow
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h1,   32'h1,  3'd1,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h2,   32'h2,  3'd2,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h3,   32'h3,  3'd3,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h4,   32'h4,  3'd4,1'b0,1'b0);
      v(1'b1,1'b1,1'b1,1'b0,1'b0,32'h5,   32'h5,  3'd4,1'b0,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h3,  3'd3,1'b0,1'b0);
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h6,   32'h6,  3'd4,1'b0,1'b0);
`ifdef PARAM_CALL_STACK_WRAP_EN
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h7,   32'h7,  3'd4,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h6,  3'd3,1'b1,1'b0);
`else
      v(1'b1,1'b1,1'b0,1'b0,1'b0,32'h7,   32'h6,  3'd4,1'b1,1'b0);
      v(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,   32'h3,  3'd3,1'b1,1'b0);
`endif

      rst_n = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      check_all(-1, 32'h0, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.en = vecs[i].en; bus.push = vecs[i].push; bus.pop = vecs[i].pop;
         bus.flush = vecs[i].flush; bus.err_clr = vecs[i].clr; bus.data_in = vecs[i].din;
         @(posedge clk);
         @(negedge clk);
         check_all(i, vecs[i].dout, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
      end

      // asynchronous reset between edges with count=3, overflow=1
      idle();
      #2 rst_n = 1'b0;
      #1 check_all(100, 32'h0, 3'd0, 1'b0, 1'b0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_all(101, 32'h0, 3'd0, 1'b0, 1'b0);
      bus.push = 1'b1; bus.data_in = 32'h77;
      @(posedge clk);
      @(negedge clk);
      check_all(102, 32'h77, 3'd1, 1'b0, 1'b0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
